load_store_unit: RTL and testbench

- Requester side of the data-memory interface: the datapath issues load/store requests, and this block drives the DataMemory ports (memwrite, endereco, writedata) and consumes readdata.
- Supports byte, halfword and word accesses, little-endian, with sign or zero extension on loads.
- Sub-word stores are done as read-modify-write, because the memory only writes whole words.
- Sits between the ALU/EX stage (address = ALU result) and DataMemory. It is a multi-cycle FSM with a valid/ready request side and a one-cycle response pulse.

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake and DataMemory port bundle of the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              memwrite;
  logic [ADDR_W-1:0] endereco;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  // Load/store unit side.
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, readdata,
    output req_ready, resp_valid, resp_rdata, resp_err, memwrite, endereco, writedata
  );

  // Datapath plus DataMemory side.
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, readdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, memwrite, endereco, writedata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store requester for a word-only DataMemory: byte/half/word
// little-endian accesses, sign/zero-extended loads, read-modify-write sub-word stores.
module load_store_unit #(
  parameter int unsigned ADDR_W          = 32,
  parameter bit          ERR_ON_MISALIGN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);
  localparam int unsigned DATA_W  = 32;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam logic [1:0]  SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e              r_state;
  state_e              w_next_state;
  logic                r_write;
  logic                r_unsigned;
  logic                r_err;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_word;

  logic                w_accept;
  logic                w_misalign;
  logic                w_err;
  logic [ADDR_W-1:0]   w_req_addr;
  logic [ADDR_W-1:0]   w_aligned;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [DATA_W-1:0]   w_load_ext;
  logic [DATA_W-1:0]   w_merge;

  assign w_accept   = (r_state == IDLE) && bus.req_valid;
  assign w_misalign = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                      ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
  assign w_err      = (bus.req_size == SZ_RSVD) || (ERR_ON_MISALIGN && w_misalign);
  assign w_aligned  = {r_addr[ADDR_W-1:2], 2'b00};

  // When misalignment is tolerated, the offending low bits are dropped at accept.
  always_comb begin
    w_req_addr = bus.req_addr;
    if (bus.req_size == SZ_HALF) begin
      w_req_addr[0] = 1'b0;
    end else if (bus.req_size == SZ_WORD) begin
      w_req_addr[1:0] = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err) begin
            w_next_state = RESP;
          end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
            w_next_state = WR;
          end else begin
            w_next_state = RD;
          end
        end
      end
      RD:      w_next_state = r_write ? WR : RESP;
      WR:      w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request latch at accept; memory word capture at the end of RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_word     <= '0;
    end else begin
      if (w_accept) begin
        r_write    <= bus.req_write;
        r_unsigned <= bus.req_unsigned;
        r_err      <= w_err;
        r_size     <= bus.req_size;
        r_addr     <= w_req_addr;
        r_wdata    <= bus.req_wdata;
      end
      if (r_state == RD) begin
        r_word <= bus.readdata;
      end
    end
  end

  assign w_byte = r_word[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? r_word[31:16] : r_word[15:0];

  always_comb begin
    w_load_ext = r_word;
    case (r_size)
      SZ_BYTE: w_load_ext = r_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_load_ext = r_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_ext = r_word;
    endcase
  end

  always_comb begin
    w_merge = r_word;
    case (r_size)
      SZ_BYTE: w_merge[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
      SZ_HALF: w_merge[{r_addr[1], 4'b0000} +: 16]  = r_wdata[15:0];
      default: w_merge = r_wdata;
    endcase
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.memwrite   = 1'b0;
    bus.endereco   = '0;
    bus.writedata  = '0;
    case (r_state)
      IDLE: bus.req_ready = rst_n;
      RD:   bus.endereco  = w_aligned;
      WR: begin
        bus.memwrite  = 1'b1;
        bus.endereco  = w_aligned;
        bus.writedata = w_merge;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = r_err;
        if (!r_err && !r_write) begin
          bus.resp_rdata = w_load_ext;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic
// against a byte-array memory model.
module tb_load_store_unit;
  localparam int unsigned ADDR_W = 32;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic mem_clr = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] mem [0:15];
  logic [7:0]  rb  [0:63];

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus0 ();
  load_store_unit_if #(.ADDR_W(ADDR_W)) bus1 ();

  load_store_unit #(.ADDR_W(ADDR_W), .ERR_ON_MISALIGN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  load_store_unit #(.ADDR_W(ADDR_W), .ERR_ON_MISALIGN(1'b0)) dut_noerr (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  always #5 clk = ~clk;

  assign bus0.readdata = mem[bus0.endereco[5:2]];
  assign bus1.readdata = {8'hA5, 16'h0000, bus1.endereco[7:0]};

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (bus0.memwrite) begin
      mem[bus0.endereco[5:2]] <= bus0.writedata;
    end
  end

  // Observation tuple: {latency, write count, response count, err, write addr, write data, rdata}.
  function automatic logic [127:0] pack_obs(input int lat, input int nwr, input int nr, input logic err,
                                            input logic [31:0] wa, input logic [31:0] wd,
                                            input logic [31:0] rd);
    return {8'(lat), 8'(nwr), 8'(nr), 7'd0, err, wa, wd, rd};
  endfunction

  function automatic bit m_err(input logic [1:0] sz, input logic [31:0] addr);
    return (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] addr);
    int b;
    b = int'({addr[5:2], 2'b00});
    return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [31:0] addr);
    logic [31:0] v;
    int b;
    b = int'(addr[5:0]);
    if (sz == 2'b00) begin
      v = {24'h0, rb[b]};
      if (!uns && rb[b][7]) v[31:8] = '1;
    end else if (sz == 2'b01) begin
      v = {16'h0, rb[b+1], rb[b]};
      if (!uns && rb[b+1][7]) v[31:16] = '1;
    end else begin
      v = m_word(addr);
    end
    return v;
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    int b, n;
    b = int'(addr[5:0]);
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) rb[b+i] = wd[8*i +: 8];
  endtask

  task automatic m_txn(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [127:0] e);
    if (m_err(sz, addr)) begin
      e = pack_obs(1, 0, 1, 1'b1, '0, '0, '0);
    end else if (!wr) begin
      e = pack_obs(2, 0, 1, 1'b0, '0, '0, m_load(sz, uns, addr));
    end else begin
      m_store(sz, addr, wd);
      e = pack_obs((sz == 2'b10) ? 2 : 3, 1, 1, 1'b0, {addr[31:2], 2'b00}, m_word(addr), '0);
    end
  endtask

  // Drives one request on bus0 and observes six cycles after the accept edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [127:0] obs);
    int lat, nwr, nr;
    logic err;
    logic [31:0] wa, wdat, rd;
    lat = 0; nwr = 0; nr = 0; err = 1'b0; wa = '0; wdat = '0; rd = '0;
    @(negedge clk);
    bus0.req_write = wr; bus0.req_size = sz; bus0.req_unsigned = uns;
    bus0.req_addr = addr; bus0.req_wdata = wd; bus0.req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus0.req_valid = 1'b0;
      if (bus0.memwrite) begin nwr++; wa = bus0.endereco; wdat = bus0.writedata; end
      if (bus0.resp_valid) begin
        nr++;
        if (lat == 0) begin lat = c; err = bus0.resp_err; rd = bus0.resp_rdata; end
      end
    end
    obs = pack_obs(lat, nwr, nr, err, wa, wdat, rd);
  endtask

  task automatic test_reset();
    logic [101:0] o;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_size = 2'b00; bus0.req_unsigned = 1'b0;
    bus0.req_addr = '0; bus0.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_size = 2'b00; bus1.req_unsigned = 1'b0;
    bus1.req_addr = '0; bus1.req_wdata = '0;
    for (int i = 0; i < 64; i++) rb[i] = '0;
    rst_n = 1'b0; mem_clr = 1'b1;
    bus0.req_valid = 1'b1;
    repeat (3) @(negedge clk);
    o = {bus0.req_ready, bus0.resp_valid, bus0.resp_err, bus0.memwrite, bus0.endereco, bus0.writedata, bus0.resp_rdata};
    n_tests++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", o); end
    bus0.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
    n_tests++;
    if (bus0.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus0.req_ready); end
  endtask

  task automatic test_word_store_load();
    logic [127:0] o, e;
    issue(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, o);
    m_store(2'b10, 32'h4, 32'hDEADBEEF);
    e = pack_obs(2, 1, 1, 1'b0, 32'h4, 32'hDEADBEEF, 32'h0);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL sw_word got=%h exp=%h", o, e); end
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, o);
    e = pack_obs(2, 0, 1, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL lw_word got=%h exp=%h", o, e); end
  endtask

  task automatic test_ext_loads();
    logic [127:0] o, e;
    logic [1:0]  szs [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        uns [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] adr [4] = '{32'h7, 32'h7, 32'h4, 32'h6};
    logic [31:0] exd [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, szs[i], uns[i], adr[i], 32'h0, o);
      e = pack_obs(2, 0, 1, 1'b0, 32'h0, 32'h0, exd[i]);
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL ext_load_%0d got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_subword_stores();
    logic [127:0] o, e;
    issue(1'b1, 2'b00, 1'b0, 32'h5, 32'hABCDEF11, o);
    m_store(2'b00, 32'h5, 32'hABCDEF11);
    e = pack_obs(3, 1, 1, 1'b0, 32'h4, 32'hDEAD11EF, 32'h0);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL sb_merge got=%h exp=%h", o, e); end
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, o);
    e = pack_obs(2, 0, 1, 1'b0, 32'h0, 32'h0, 32'hDEAD11EF);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL sb_readback got=%h exp=%h", o, e); end
    issue(1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678, o);
    m_store(2'b10, 32'h8, 32'h12345678);
    issue(1'b1, 2'b01, 1'b0, 32'hA, 32'h9999CAFE, o);
    m_store(2'b01, 32'hA, 32'h9999CAFE);
    e = pack_obs(3, 1, 1, 1'b0, 32'h8, 32'hCAFE5678, 32'h0);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL sh_merge got=%h exp=%h", o, e); end
  endtask

  task automatic test_errors();
    logic [127:0] o, e;
    logic        wrs [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  szs [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] adr [3] = '{32'h6, 32'h3, 32'h0};
    e = pack_obs(1, 0, 1, 1'b1, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      issue(wrs[i], szs[i], 1'b0, adr[i], 32'hFFFFFFFF, o);
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL error_%0d got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_handshake();
    int acc, nr, acc2_at;
    logic [31:0] last_rd, exp_rd;
    acc = 0; nr = 0; acc2_at = -1; last_rd = '0;
    m_store(2'b00, 32'h9, 32'h0000005A);
    exp_rd = m_load(2'b10, 1'b0, 32'h8);
    @(negedge clk);
    bus0.req_write = 1'b1; bus0.req_size = 2'b00; bus0.req_unsigned = 1'b0;
    bus0.req_addr = 32'h9; bus0.req_wdata = 32'h0000005A; bus0.req_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (bus0.resp_valid) begin nr++; last_rd = bus0.resp_rdata; end
      if (acc == 2) bus0.req_valid = 1'b0;
      if (bus0.req_ready && bus0.req_valid) begin
        acc++;
        if (acc == 2) acc2_at = c;
      end else if (acc == 1) begin
        bus0.req_write = 1'b0; bus0.req_size = 2'b10; bus0.req_addr = 32'h8; bus0.req_wdata = '0;
      end
    end
    n_tests++;
    if ({8'(acc), 8'(nr), 8'(acc2_at)} !== {8'd2, 8'd2, 8'd4}) begin
      n_fail++;
      $display("FAIL handshake accepts=%0d resps=%0d second_at=%0d exp 2/2/4", acc, nr, acc2_at);
    end
    n_tests++;
    if (last_rd !== exp_rd) begin n_fail++; $display("FAIL handshake_load got=%h exp=%h", last_rd, exp_rd); end
  endtask

  task automatic test_reset_mid_op();
    logic [127:0] o, e;
    logic [101:0] z;
    int nr;
    nr = 0;
    @(negedge clk);
    bus0.req_write = 1'b1; bus0.req_size = 2'b00; bus0.req_unsigned = 1'b0;
    bus0.req_addr = 32'h5; bus0.req_wdata = 32'h00000077; bus0.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus0.memwrite !== 1'b1) begin n_fail++; $display("FAIL rst_wr_phase memwrite got=%b exp=1", bus0.memwrite); end
    rst_n = 1'b0;
    #1;
    z = {bus0.req_ready, bus0.resp_valid, bus0.resp_err, bus0.memwrite, bus0.endereco, bus0.writedata, bus0.resp_rdata};
    n_tests++;
    if (z !== '0) begin n_fail++; $display("FAIL rst_midop_outputs got=%h exp=0", z); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus0.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got=%b exp=1", bus0.req_ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus0.resp_valid) nr++;
    end
    n_tests++;
    if (nr !== 0) begin n_fail++; $display("FAIL rst_no_resp got=%0d exp=0", nr); end
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, o);
    e = pack_obs(2, 0, 1, 1'b0, 32'h0, 32'h0, m_load(2'b10, 1'b0, 32'h4));
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL rst_after_load got=%h exp=%h", o, e); end
  endtask

  task automatic test_random();
    logic [127:0] o, e;
    logic wr, uns;
    logic [1:0] sz;
    logic [31:0] addr, wd;
    for (int i = 0; i < 60; i++) begin
      wr   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = $urandom();
      wd   = $urandom();
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'b01) addr[0] = 1'b0;
        if (sz == 2'b10) addr[1:0] = 2'b00;
      end
      m_txn(wr, sz, uns, addr, wd, e);
      issue(wr, sz, uns, addr, wd, o);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random_%0d wr=%b sz=%b uns=%b addr=%h got=%h exp=%h", i, wr, sz, uns, addr, o, e);
      end
    end
  endtask

  task automatic test_noerr_param();
    logic [1:0]  szs [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] adr [3] = '{32'h6, 32'h5, 32'h0};
    logic [32:0] exp1 [3] = '{{1'b0, 32'h4}, {1'b0, 32'h4}, {1'b1, 32'h0}};
    logic [33:0] exp2 [3] = '{{2'b10, 32'hA5000004}, {2'b10, 32'h00000004}, {2'b00, 32'h0}};
    logic [32:0] o1;
    logic [33:0] o2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus1.req_write = 1'b0; bus1.req_size = szs[i]; bus1.req_unsigned = 1'b0;
      bus1.req_addr = adr[i]; bus1.req_wdata = '0; bus1.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.req_valid = 1'b0;
      o1 = (szs[i] == 2'b11) ? {bus1.resp_valid & bus1.resp_err, bus1.endereco}
                             : {bus1.resp_valid | bus1.memwrite, bus1.endereco};
      n_tests++;
      if (o1 !== exp1[i]) begin n_fail++; $display("FAIL noerr_phase1_%0d got=%h exp=%h", i, o1, exp1[i]); end
      @(negedge clk);
      o2 = {bus1.resp_valid, bus1.resp_err, bus1.resp_rdata};
      n_tests++;
      if (o2 !== exp2[i]) begin n_fail++; $display("FAIL noerr_phase2_%0d got=%h exp=%h", i, o2, exp2[i]); end
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_ext_loads();
    test_subword_stores();
    test_errors();
    test_handshake();
    test_reset_mid_op();
    test_random();
    test_noerr_param();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
